// File: rtl/cw305_host_ctrl_pkg.sv
// Shared constants for the CW305 host register front end: register map,
// FSM state encoding and STATUS bit positions.
package cw305_host_pkg;

  // Byte addresses on the USB register bus
  localparam logic [5:0] PT_BASE      = 6'h00;
  localparam logic [5:0] CT_BASE      = 6'h10;
  localparam logic [5:0] CTRL         = 6'h20;
  localparam logic [5:0] STATUS       = 6'h21;
  localparam logic [5:0] TIMEOUT_BASE = 6'h22;
  localparam logic [5:0] CYC_BASE     = 6'h26;

  // Run sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    RUN       = 2'd3
  } state_e;

  // STATUS register bit positions
  localparam int STAT_ACTIVE  = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_BUSY    = 3;

endpackage

// File: rtl/cw305_host_ctrl_if.sv
// Bundle of the USB register bus and the mailbox handshake. The master side
// is the USB host plus mailbox; the slave side is the host controller.
interface cw305_host_ctrl_if;
  logic [5:0]   reg_addr;
  logic [7:0]   reg_wdata;
  logic         reg_write;
  logic         reg_read;
  logic [7:0]   reg_rdata;
  logic         start;
  logic [127:0] pt;
  logic         busy;
  logic [127:0] ct;
  logic         trigger;

  modport master (
    output reg_addr, reg_wdata, reg_write, reg_read, busy, ct,
    input  reg_rdata, start, pt, trigger
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_write, reg_read, busy, ct,
    output reg_rdata, start, pt, trigger
  );
endinterface

// File: rtl/cw305_host_ctrl_cycle_timer.sv
// 32-bit saturating run-length counter. cycles_o is the number of active
// cycles including the current one, so a limit of N expires on the N-th
// active cycle.
module cw305_cycle_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [31:0] limit_i,
  output logic [31:0] cycles_o,
  output logic        expired_o
);
  logic [31:0] count_q;
  logic [31:0] count_d;

  assign count_d   = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
  assign cycles_o  = count_d;
  assign expired_o = enable_i && (limit_i != 32'd0) && (count_d == limit_i);

  // Counter register: clear wins over increment
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= 32'd0;
    end else if (clear_i) begin
      count_q <= 32'd0;
    end else if (enable_i) begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/cw305_host_ctrl.sv
// CW305 host front end: byte-wide register file, one-shot start to the AXI
// mailbox, busy tracking, ciphertext capture, cycle count and timeout.
module cw305_host_ctrl
  import cw305_host_pkg::*;
#(
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'd1_000_000
) (
  input logic              clk,
  input logic              resetn,
  cw305_host_ctrl_if.slave bus
);
  state_e       state_q, state_d;
  logic [127:0] pt_q, ct_q;
  logic [31:0]  timeout_q, last_q;
  logic         done_q, tout_q;
  logic [7:0]   rdata_q, rdata_d;

  logic         idle, go;
  logic         tmr_clear, tmr_en, tmr_expired;
  logic         capture, expire;
  logic [31:0]  cycles;
  logic         is_tout_addr, is_cyc_addr;
  logic [1:0]   tout_idx, cyc_idx;
  logic [7:0]   status;

  assign idle         = (state_q == IDLE);
  assign go           = bus.reg_write && (bus.reg_addr == CTRL) && bus.reg_wdata[0];
  assign is_tout_addr = (bus.reg_addr >= TIMEOUT_BASE) && (bus.reg_addr < CYC_BASE);
  assign is_cyc_addr  = (bus.reg_addr >= CYC_BASE) && (bus.reg_addr < CYC_BASE + 6'd4);
  assign tout_idx     = 2'(bus.reg_addr - TIMEOUT_BASE);
  assign cyc_idx      = 2'(bus.reg_addr - CYC_BASE);

  assign bus.start     = (state_q == START);
  assign bus.trigger   = !idle;
  assign bus.pt        = pt_q;
  assign bus.reg_rdata = rdata_q;

  cw305_cycle_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .limit_i   (timeout_q),
    .cycles_o  (cycles),
    .expired_o (tmr_expired)
  );

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and run events; completion is tested before timeout
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go && !bus.busy) begin
          tmr_clear = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        tmr_en  = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          expire  = 1'b1;
          state_d = IDLE;
        end else if (bus.busy) begin
          state_d = RUN;
        end
      end
      RUN: begin
        tmr_en = 1'b1;
        if (!bus.busy) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (tmr_expired) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Run results: done/timeout flags, ciphertext and last cycle count
  // NOTE: the register file is a handful of flops, so it is reset like any other state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q <= 1'b0;
      tout_q <= 1'b0;
      ct_q   <= '0;
      last_q <= '0;
    end else begin
      if (tmr_clear) begin
        done_q <= 1'b0;
        tout_q <= 1'b0;
      end
      if (capture) begin
        done_q <= 1'b1;
        ct_q   <= bus.ct;
        last_q <= cycles;
      end
      if (expire) begin
        tout_q <= 1'b1;
        last_q <= cycles;
      end
    end
  end

  // Host-writable registers; frozen while a run is in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pt_q      <= '0;
      timeout_q <= DEFAULT_TIMEOUT;
    end else if (bus.reg_write && idle) begin
      if (bus.reg_addr[5:4] == PT_BASE[5:4]) begin
        pt_q[{bus.reg_addr[3:0], 3'b000} +: 8] <= bus.reg_wdata;
      end
      if (is_tout_addr) begin
        timeout_q[{tout_idx, 3'b000} +: 8] <= bus.reg_wdata;
      end
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    status               = 8'h00;
    status[STAT_ACTIVE]  = !idle;
    status[STAT_DONE]    = done_q;
    status[STAT_TIMEOUT] = tout_q;
    status[STAT_BUSY]    = bus.busy;
    rdata_d              = 8'h00;
    if (bus.reg_addr[5:4] == PT_BASE[5:4]) begin
      rdata_d = pt_q[{bus.reg_addr[3:0], 3'b000} +: 8];
    end else if (bus.reg_addr[5:4] == CT_BASE[5:4]) begin
      rdata_d = ct_q[{bus.reg_addr[3:0], 3'b000} +: 8];
    end else if (bus.reg_addr == STATUS) begin
      rdata_d = status;
    end else if (is_tout_addr) begin
      rdata_d = timeout_q[{tout_idx, 3'b000} +: 8];
    end else if (is_cyc_addr) begin
      rdata_d = last_q[{cyc_idx, 3'b000} +: 8];
    end
  end

  // Read data register, updated only on a read strobe
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           rdata_q <= 8'h00;
    else if (bus.reg_read) rdata_q <= rdata_d;
  end
endmodule

// File: tb/tb_cw305_host_ctrl.sv
// Self-checking bench for cw305_host_ctrl: behavioural mailbox, register
// model and a read scoreboard drained by an independent monitor.
module tb_cw305_host_ctrl;
  import cw305_host_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cw305_host_ctrl_if bus();

  cw305_host_ctrl #(.DEFAULT_TIMEOUT(32'd1_000_000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- mailbox model ----------------
  int unsigned  mb_lat  = 1;
  int unsigned  mb_left = 0;
  logic [127:0] mb_ct   = '0;
  bit           mb_kill = 1'b0;
  int           start_cnt = 0;

  always @(posedge clk) begin
    if (bus.start) begin
      mb_left   <= mb_lat;
      start_cnt <= start_cnt + 1;
    end else if (mb_kill) begin
      mb_left <= 0;
    end else if (mb_left != 0) begin
      mb_left <= mb_left - 1;
    end
  end
  assign bus.busy = (mb_left != 0);
  assign bus.ct   = bus.busy ? ~mb_ct : mb_ct;

  // ---------------- register model ----------------
  logic [7:0]  m_pt[16];
  logic [7:0]  m_ct[16];
  logic [31:0] m_timeout, m_last;
  bit          m_done, m_to, m_active;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pt[i] = 8'h00;
      m_ct[i] = 8'h00;
    end
    m_timeout = 32'd1_000_000;
    m_last    = 32'd0;
    m_done    = 1'b0;
    m_to      = 1'b0;
    m_active  = 1'b0;
  endfunction

  function automatic logic [127:0] model_pt();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = m_pt[i];
    return v;
  endfunction

  function automatic logic [7:0] model_rd(input logic [5:0] a);
    int k = int'(a);
    if (k < 16)                return m_pt[k];
    if (k < 32)                return m_ct[k - 16];
    if (k == 33)               return {4'b0000, bus.busy, m_to, m_done, m_active};
    if (k >= 34 && k <= 37)    return 8'(m_timeout >> (8 * (k - 34)));
    if (k >= 38 && k <= 41)    return 8'(m_last >> (8 * (k - 38)));
    return 8'h00;
  endfunction

  function automatic void model_wr(input logic [5:0] a, input logic [7:0] d);
    int k = int'(a);
    if (m_active) return;
    if (k < 16) m_pt[k] = d;
    if (k >= 34 && k <= 37) m_timeout[8 * (k - 34) +: 8] = d;
  endfunction

  // ---------------- read scoreboard ----------------
  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  logic    rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= bus.reg_read;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%0h with no expectation queued", bus.reg_rdata);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rd[%02h]", e.addr), bus.reg_rdata, e.data);
      end
    end
  end

  // ---------------- bus tasks (enter and leave at a negedge) ----------------
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    model_wr(a, d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_write = 1'b1;
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    rd_exp_t e;
    e.addr = a;
    e.data = model_rd(a);
    exp_q.push_back(e);
    bus.reg_addr = a;
    bus.reg_read = 1'b1;
    @(negedge clk);
    bus.reg_read = 1'b0;
  endtask

  task automatic rw(input logic [5:0] a, input logic [7:0] d);
    rd_exp_t e;
    e.addr = a;
    e.data = model_rd(a);
    exp_q.push_back(e);
    model_wr(a, d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_write = 1'b1;
    bus.reg_read  = 1'b1;
    @(negedge clk);
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
  endtask

  task automatic wr_pt(input logic [127:0] v);
    for (int i = 0; i < 16; i++) wr(6'(i), v[8*i +: 8]);
  endtask

  task automatic wr_timeout(input logic [31:0] v);
    for (int i = 0; i < 4; i++) wr(6'(int'(TIMEOUT_BASE) + i), v[8*i +: 8]);
  endtask

  task automatic rd_results();
    rd(STATUS);
    for (int i = 0; i < 16; i++) rd(6'(int'(CT_BASE) + i));
    for (int i = 0; i < 4; i++) rd(6'(int'(CYC_BASE) + i));
  endtask

  task automatic wait_mb_idle();
    int n = 0;
    while (bus.busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("mb_idle_bound", bus.busy, 1'b0);
  endtask

  // ---------------- run tasks ----------------
  int           run_r, run_s0;
  bit           run_to;
  logic [127:0] run_ct;

  // Issue GO; the run length follows from the timeout rules and mailbox latency
  task automatic go_begin(input int unsigned lat, input logic [127:0] ct);
    mb_lat = lat;
    mb_ct  = ct;
    run_ct = ct;
    run_to = (m_timeout != 0) && (m_timeout >= 2) && (m_timeout < 64'(lat) + 2);
    run_r  = run_to ? int'(m_timeout) : int'(lat) + 2;
    run_s0 = start_cnt;
    wr(CTRL, 8'h01);
    m_active = 1'b1;
    m_done   = 1'b0;
    m_to     = 1'b0;
    check("start_at_T1", bus.start, 1'b1);
    check("trigger_at_T1", bus.trigger, 1'b1);
    check("pt_at_start", bus.pt, model_pt());
  endtask

  task automatic go_finish(input int elapsed);
    repeat (run_r - elapsed) @(negedge clk);
    check("trigger_last_cycle", bus.trigger, 1'b1);
    @(negedge clk);
    check("trigger_after_end", bus.trigger, 1'b0);
    check("one_start_pulse", 32'(start_cnt - run_s0), 32'd1);
    m_active = 1'b0;
    m_last   = 32'(run_r);
    if (run_to) begin
      m_to = 1'b1;
    end else begin
      m_done = 1'b1;
      for (int i = 0; i < 16; i++) m_ct[i] = run_ct[8*i +: 8];
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    bus.reg_addr  = 6'h00;
    bus.reg_wdata = 8'h00;
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state and basic readback
    check("rst_trigger", bus.trigger, 1'b0);
    check("rst_start", bus.start, 1'b0);
    check("rst_pt", bus.pt, '0);
    check("rst_rdata", bus.reg_rdata, 8'h00);
    rd(STATUS);
    rd(CT_BASE);
    rd(CYC_BASE);
    rd(6'h3F);
    for (int i = 0; i < 4; i++) rd(6'(int'(TIMEOUT_BASE) + i));
    rd(6'(int'(TIMEOUT_BASE) + 1));
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.reg_rdata, 8'h42);

    // Normal run
    wr_pt(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    go_begin(50, 128'h69C4_E0D8_6A7B_0430_D8CD_B780_70B4_C55A);
    go_finish(1);
    check("normal_last_cycles", m_last, 32'd52);
    rd_results();

    // Simultaneous read and write at the same address
    rw(6'h03, 8'hA5);
    rd(6'h03);

    // Writes and GO during RUN are ignored
    go_begin(30, rand128());
    repeat (3) @(negedge clk);
    wr(6'h00, 8'hEE);
    wr(TIMEOUT_BASE, 8'h07);
    wr(CTRL, 8'h01);
    rd(STATUS);
    go_finish(8);
    check("pt_protected", bus.pt, model_pt());
    rd(6'h00);
    rd(TIMEOUT_BASE);
    rd_results();

    // Back-to-back runs with different plaintexts
    s = start_cnt;
    for (int r = 0; r < 2; r++) begin
      wr_pt(rand128());
      go_begin($urandom_range(5, 20), rand128());
      rd(STATUS);
      go_finish(2);
      rd_results();
    end
    check("two_start_pulses", 32'(start_cnt - s), 32'd2);

    // Timeout with a hung mailbox
    wr_timeout(32'd20);
    go_begin(100_000, rand128());
    go_finish(1);
    rd_results();
    s = start_cnt;
    wr(CTRL, 8'h01);
    repeat (3) @(negedge clk);
    check("go_ignored_while_busy", 32'(start_cnt - s), 32'd0);
    check("trigger_idle_while_busy", bus.trigger, 1'b0);
    rd(STATUS);
    mb_kill = 1'b1;
    @(negedge clk);
    mb_kill = 1'b0;
    wait_mb_idle();

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      logic [31:0] to;
      wr_pt(rand128());
      case ($urandom_range(0, 2))
        0:       to = 32'd0;
        1:       to = 32'($urandom_range(2, 40));
        default: to = 32'd1_000_000;
      endcase
      wr_timeout(to);
      go_begin($urandom_range(1, 35), rand128());
      go_finish(1);
      wait_mb_idle();
      rd_results();
      rd(6'($urandom_range(0, 63)));
    end

    // Asynchronous reset in the middle of RUN
    wr_timeout(32'd0);
    go_begin(40, rand128());
    repeat (10) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_trigger", bus.trigger, 1'b0);
    check("async_rst_start", bus.start, 1'b0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    rd(STATUS);
    for (int i = 0; i < 4; i++) rd(6'(int'(TIMEOUT_BASE) + i));
    rd(CT_BASE);
    rd(CYC_BASE);
    repeat (3) @(negedge clk);
    check("no_start_after_reset", 32'(start_cnt - run_s0), 32'd1);
    mb_kill = 1'b1;
    @(negedge clk);
    mb_kill = 1'b0;
    wait_mb_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
